irrigation_zone_sequencer: RTL and testbench

Parametrised multi-zone successor to the single-tank irrigation controller. It fills the tank from level sensors, then waters NUM_ZONES zones in ascending order. Each zone runs for a programmable duration in sprinkler (optionally agro-dosed) or drip mode. It handles refill-and-resume on low water, an optional timed cleaning cycle, and latched error reporting. It sits between the sensor/keypad front-end and the valve/pump drivers.

---
 rtl/irrigation_pkg.sv | 36 +++
 rtl/zone_timer.sv | 27 ++
 rtl/irrigation_zone_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_irrigation_zone_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared types, error codes and zone-selection helpers for the irrigation zone sequencer.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WATER = 3'd2,
    ST_NEXT  = 3'd3,
    ST_CLEAN = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_EXT    = 2'd1;
  localparam logic [1:0] ERR_FILL   = 2'd2;
  localparam logic [1:0] ERR_SENSOR = 2'd3;

  localparam int MAX_ZONES = 8;

  // Bit offset of a zone's duration field inside the packed zone_time bus.
  function automatic int zone_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  // Lowest candidate zone at or above 'from'; result is {found, index}.
  function automatic logic [3:0] pick_zone(input logic [MAX_ZONES-1:0] cand,
                                           input logic [3:0] from);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = MAX_ZONES - 1; i >= 0; i--) begin
      if (cand[i] && (i >= int'(from))) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/zone_timer.sv
// Loadable down-counter with hold; expire flags the final counting cycle (count == 1).
module zone_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/irrigation_zone_sequencer.sv
// Multi-zone irrigation sequencer: fill tank, water enabled zones in order, refill/resume,
// optional timed cleaning and latched error reporting. Outputs are decoded from registers only.
module irrigation_zone_sequencer
  import irrigation_pkg::*;
#(
  parameter int NUM_ZONES    = 4,
  parameter int TIMER_W      = 16,
  parameter int FILL_TIMEOUT = 1000,
  parameter int CLEAN_CYCLES = 50
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         H,
  input  logic                         M,
  input  logic                         L,
  input  logic                         E,
  input  logic                         err_clr,
  input  logic                         start,
  input  logic                         clean_req,
  input  logic [NUM_ZONES-1:0]         zone_enable,
  input  logic [NUM_ZONES-1:0]         zone_mode,
  input  logic [NUM_ZONES-1:0]         zone_agro,
  input  logic [NUM_ZONES*TIMER_W-1:0] zone_time,
  output logic                         S_Enchendo,
  output logic                         S_Aspersao,
  output logic                         S_Agro,
  output logic                         S_Gotejamento,
  output logic                         S_Limpeza,
  output logic                         S_Erro,
  output logic [NUM_ZONES-1:0]         zone_valve,
  output logic [2:0]                   cur_zone,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   err_code
);

  state_t               state_q, state_d;
  logic [2:0]           cur_zone_q, zone_d;
  logic                 resume_q, resume_d;
  logic                 clean_flag_q, clean_entry;
  logic                 done_q, done_d;
  logic [1:0]           err_code_q, err_d;
  logic [MAX_ZONES-1:0] qual, mode_in, agro_in, mode_q, agro_q;
  logic [TIMER_W-1:0]   times [MAX_ZONES];
  logic [3:0]           first_pick, next_pick;
  logic                 start_ok, fault, load_water;
  logic                 water_last, fill_last, clean_last;
  logic [1:0]           fault_code;
  logic                 in_water;

  // Zone inputs padded to eight entries so the search and indexing are width-independent.
  for (genvar g = 0; g < MAX_ZONES; g++) begin : g_zone
    if (g < NUM_ZONES) begin : g_real
      assign times[g]   = zone_time[zone_lsb(g, TIMER_W) +: TIMER_W];
      assign qual[g]    = zone_enable[g] && (times[g] != '0);
      assign mode_in[g] = zone_mode[g];
      assign agro_in[g] = zone_agro[g];
    end else begin : g_pad
      assign times[g]   = '0;
      assign qual[g]    = 1'b0;
      assign mode_in[g] = 1'b0;
      assign agro_in[g] = 1'b0;
    end
  end

  assign first_pick = pick_zone(qual, 4'd0);
  assign next_pick  = pick_zone(qual, {1'b0, cur_zone_q} + 4'd1);
  assign start_ok   = start && first_pick[3];
  assign fault      = E || (H && !M) || (M && !L);
  assign fault_code = E ? ERR_EXT : ERR_SENSOR;

  zone_timer #(.W(TIMER_W)) u_water_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (load_water),
    .en       (state_q == ST_WATER),
    .load_val (times[zone_d]),
    .expire   (water_last)
  );

  // Fill and clean timers preload while idle in other states so entry starts a full count.
  zone_timer #(.W(TIMER_W)) u_fill_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (state_q != ST_FILL),
    .en       (state_q == ST_FILL),
    .load_val (TIMER_W'(FILL_TIMEOUT)),
    .expire   (fill_last)
  );

  zone_timer #(.W(TIMER_W)) u_clean_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (state_q != ST_CLEAN),
    .en       (state_q == ST_CLEAN),
    .load_val (TIMER_W'(CLEAN_CYCLES)),
    .expire   (clean_last)
  );

  always_comb begin
    state_d     = state_q;
    zone_d      = cur_zone_q;
    resume_d    = resume_q;
    err_d       = err_code_q;
    load_water  = 1'b0;
    done_d      = 1'b0;
    clean_entry = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok || clean_flag_q) begin
          if (fault) begin
            state_d = ST_ERROR;
            err_d   = fault_code;
          end else if (start_ok) begin
            state_d  = ST_FILL;
            zone_d   = first_pick[2:0];
            resume_d = 1'b0;
          end else begin
            state_d     = ST_CLEAN;
            clean_entry = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (fault) begin
          state_d = ST_ERROR;
          err_d   = fault_code;
        end else if (H) begin
          state_d    = ST_WATER;
          load_water = !resume_q;
          resume_d   = 1'b0;
        end else if (fill_last) begin
          state_d = ST_ERROR;
          err_d   = ERR_FILL;
        end
      end
      ST_WATER: begin
        if (fault) begin
          state_d = ST_ERROR;
          err_d   = fault_code;
        end else if (water_last) begin
          state_d = ST_NEXT;
        end else if (!L) begin
          state_d  = ST_FILL;
          resume_d = 1'b1;
        end
      end
      ST_NEXT: begin
        if (fault) begin
          state_d = ST_ERROR;
          err_d   = fault_code;
        end else if (next_pick[3]) begin
          zone_d   = next_pick[2:0];
          resume_d = 1'b0;
          if (L) begin
            state_d    = ST_WATER;
            load_water = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          done_d = 1'b1;
          zone_d = 3'd0;
          if (clean_flag_q) begin
            state_d     = ST_CLEAN;
            clean_entry = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CLEAN: begin
        if (fault) begin
          state_d = ST_ERROR;
          err_d   = fault_code;
        end else if (clean_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_clr && !E) begin
          state_d  = ST_IDLE;
          err_d    = ERR_NONE;
          zone_d   = 3'd0;
          resume_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cur_zone_q   <= 3'd0;
      resume_q     <= 1'b0;
      clean_flag_q <= 1'b0;
      done_q       <= 1'b0;
      err_code_q   <= ERR_NONE;
      mode_q       <= '0;
      agro_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_zone_q <= zone_d;
      resume_q   <= resume_d;
      done_q     <= done_d;
      err_code_q <= err_d;
      mode_q     <= mode_in;
      agro_q     <= agro_in;
      if (clean_req) begin
        clean_flag_q <= 1'b1;
      end else if (clean_entry) begin
        clean_flag_q <= 1'b0;
      end
    end
  end

  assign in_water = (state_q == ST_WATER);

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_valve
    assign zone_valve[g] = in_water && (cur_zone_q == 3'(g));
  end

  assign S_Enchendo    = (state_q == ST_FILL);
  assign S_Aspersao    = in_water && mode_q[cur_zone_q];
  assign S_Agro        = in_water && mode_q[cur_zone_q] && agro_q[cur_zone_q];
  assign S_Gotejamento = in_water && !mode_q[cur_zone_q];
  assign S_Limpeza     = (state_q == ST_CLEAN);
  assign S_Erro        = (state_q == ST_ERROR);
  assign cur_zone      = cur_zone_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Directed bench for irrigation_zone_sequencer with hand-computed expectations per step.
module tb_irrigation_zone_sequencer;

  localparam int NZ = 4;
  localparam int TW = 16;

  logic          Clock, Reset, H, M, L, E, err_clr, start, clean_req;
  logic [NZ-1:0] zone_enable, zone_mode, zone_agro, zone_valve;
  logic [NZ*TW-1:0] zone_time;
  logic          S_Enchendo, S_Aspersao, S_Agro, S_Gotejamento, S_Limpeza, S_Erro;
  logic [2:0]    cur_zone;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [5:0]    act;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] A_OFF   = 6'b000000;
  localparam logic [5:0] A_FILL  = 6'b100000;
  localparam logic [5:0] A_SPRAG = 6'b011000;
  localparam logic [5:0] A_DRIP  = 6'b000100;
  localparam logic [5:0] A_CLEAN = 6'b000010;
  localparam logic [5:0] A_ERR   = 6'b000001;

  irrigation_zone_sequencer #(
    .NUM_ZONES(NZ), .TIMER_W(TW), .FILL_TIMEOUT(20), .CLEAN_CYCLES(50)
  ) dut (
    .Clock(Clock), .Reset(Reset), .H(H), .M(M), .L(L), .E(E),
    .err_clr(err_clr), .start(start), .clean_req(clean_req),
    .zone_enable(zone_enable), .zone_mode(zone_mode), .zone_agro(zone_agro),
    .zone_time(zone_time),
    .S_Enchendo(S_Enchendo), .S_Aspersao(S_Aspersao), .S_Agro(S_Agro),
    .S_Gotejamento(S_Gotejamento), .S_Limpeza(S_Limpeza), .S_Erro(S_Erro),
    .zone_valve(zone_valve), .cur_zone(cur_zone), .busy(busy), .done(done),
    .err_code(err_code)
  );

  assign act = {S_Enchendo, S_Aspersao, S_Agro, S_Gotejamento, S_Limpeza, S_Erro};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] a, input logic [3:0] v,
                         input logic b, input logic [2:0] z);
    chk({tag, "/act"}, 16'(act), 16'(a));
    chk({tag, "/valve"}, 16'(zone_valve), 16'(v));
    chk({tag, "/busy"}, 16'(busy), 16'(b));
    chk({tag, "/zone"}, 16'(cur_zone), 16'(z));
  endtask

  initial begin
    Reset = 1'b1; H = 1'b0; M = 1'b0; L = 1'b0; E = 1'b0;
    err_clr = 1'b0; start = 1'b0; clean_req = 1'b0;
    zone_enable = 4'b0101; zone_mode = 4'b0001; zone_agro = 4'b0001;
    zone_time = {16'd0, 16'd3, 16'd10, 16'd5};
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk_out("reset", A_OFF, 4'b0000, 1'b0, 3'd0);
    chk("reset/done", 16'(done), 16'd0);
    chk("reset/err", 16'(err_code), 16'd0);

    // Round over zones 0 (sprinkler+agro, 5) and 2 (drip, 3).
    H = 1'b1; M = 1'b1; L = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("r1_fill", A_FILL, 4'b0000, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("r1_z0", A_SPRAG, 4'b0001, 1'b1, 3'd0);
    end
    tick();
    chk_out("r1_next", A_OFF, 4'b0000, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("r1_z2", A_DRIP, 4'b0100, 1'b1, 3'd2);
    end
    tick();
    chk_out("r1_next2", A_OFF, 4'b0000, 1'b1, 3'd2);
    chk("r1_next2/done", 16'(done), 16'd0);
    tick();
    chk_out("r1_idle", A_OFF, 4'b0000, 1'b0, 3'd0);
    chk("r1_done", 16'(done), 16'd1);
    tick();
    chk("r1_done_pulse", 16'(done), 16'd0);

    // Zone 1 drip for 10 cycles, low water after 4, resume for the remaining 6.
    zone_enable = 4'b0010;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("r2_fill", A_FILL, 4'b0000, 1'b1, 3'd1);
    tick();
    chk_out("r2_w1", A_DRIP, 4'b0010, 1'b1, 3'd1);
    tick(); tick(); tick();
    chk_out("r2_w4", A_DRIP, 4'b0010, 1'b1, 3'd1);
    H = 1'b0; M = 1'b0; L = 1'b0;
    tick();
    chk_out("r2_refill", A_FILL, 4'b0000, 1'b1, 3'd1);
    tick();
    chk_out("r2_refill2", A_FILL, 4'b0000, 1'b1, 3'd1);
    H = 1'b1; M = 1'b1; L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("r2_resume", A_DRIP, 4'b0010, 1'b1, 3'd1);
    end
    tick();
    chk_out("r2_next", A_OFF, 4'b0000, 1'b1, 3'd1);
    tick();
    chk("r2_done", 16'(done), 16'd1);
    chk("r2_idle", 16'(busy), 16'd0);

    // Fill timeout after 20 FILL cycles.
    zone_enable = 4'b0001;
    H = 1'b0; M = 1'b1; L = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    chk_out("to_fill20", A_FILL, 4'b0000, 1'b1, 3'd0);
    tick();
    chk_out("to_err", A_ERR, 4'b0000, 1'b1, 3'd0);
    chk("to_code", 16'(err_code), 16'd2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_clr_busy", 16'(busy), 16'd0);
    chk("to_clr_code", 16'(err_code), 16'd0);

    // External fault during watering; clear ignored while E is high.
    H = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk_out("ext_water", A_SPRAG, 4'b0001, 1'b1, 3'd0);
    E = 1'b1; tick();
    chk_out("ext_err", A_ERR, 4'b0000, 1'b1, 3'd0);
    chk("ext_code", 16'(err_code), 16'd1);
    err_clr = 1'b1; tick();
    chk("ext_clr_ign", 16'(S_Erro), 16'd1);
    chk("ext_code_held", 16'(err_code), 16'd1);
    err_clr = 1'b0; E = 1'b0; tick();
    chk("ext_hold", 16'(S_Erro), 16'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk_out("ext_clr", A_OFF, 4'b0000, 1'b0, 3'd0);
    chk("ext_clr_code", 16'(err_code), 16'd0);

    // Sensor inconsistency on start.
    zone_enable = 4'b0100;
    H = 1'b1; M = 1'b0; L = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("sens_err", 16'(S_Erro), 16'd1);
    chk("sens_code", 16'(err_code), 16'd3);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("sens_clr", 16'(busy), 16'd0);

    // Cleaning requested mid-round runs 50 cycles after the done pulse.
    M = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    clean_req = 1'b1; tick(); clean_req = 1'b0;
    chk_out("cl_z2", A_DRIP, 4'b0100, 1'b1, 3'd2);
    tick(); tick(); tick();
    chk_out("cl_next", A_OFF, 4'b0000, 1'b1, 3'd2);
    tick();
    chk_out("cl_c1", A_CLEAN, 4'b0000, 1'b1, 3'd0);
    chk("cl_done", 16'(done), 16'd1);
    for (int i = 2; i <= 50; i++) tick();
    chk_out("cl_c50", A_CLEAN, 4'b0000, 1'b1, 3'd0);
    tick();
    chk_out("cl_idle", A_OFF, 4'b0000, 1'b0, 3'd0);
    tick();
    chk("cl_no_repeat", 16'(busy), 16'd0);

    // Reset mid-watering, then start with nothing qualifying.
    zone_enable = 4'b0001;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk_out("rst_water", A_SPRAG, 4'b0001, 1'b1, 3'd0);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk_out("rst_mid", A_OFF, 4'b0000, 1'b0, 3'd0);
    chk("rst_mid_done", 16'(done), 16'd0);
    zone_enable = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("no_zone", A_OFF, 4'b0000, 1'b0, 3'd0);
    zone_enable = 4'b1000;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("zero_time", A_OFF, 4'b0000, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
